// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared sample types and sequencer state encoding for codec_seq
package codec_pkg;

    localparam int SMP_W = 16;

    typedef struct packed {
        logic signed [SMP_W-1:0] lft;
        logic signed [SMP_W-1:0] rht;
    } smp_pair_t;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } codec_state_e;

endpackage

// File: rtl/codec_seq_tmr.sv
// rtl/codec_seq_tmr.sv - loadable up-counter flagging terminal count N-1
module codec_seq_tmr #(
    parameter int N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(N - 1));

endmodule

// File: rtl/codec_seq.sv
// rtl/codec_seq.sv - codec power-up sequencer and sample handoff; CODEC_SEQ_STATS_EN adds event counters
module codec_seq
    import codec_pkg::*;
#(
    parameter int RST_CYC    = 1024,
    parameter int SETTLE_FRM = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart,
    input  logic                    intf_valid,
    input  logic signed [SMP_W-1:0] lft_in,
    input  logic signed [SMP_W-1:0] rht_in,
    input  logic                    smp_rdy,
    input  logic                    proc_vld,
    input  logic signed [SMP_W-1:0] proc_lft,
    input  logic signed [SMP_W-1:0] proc_rht,
    output logic                    codec_rst_n,
    output logic                    smp_vld,
    output logic signed [SMP_W-1:0] smp_lft,
    output logic signed [SMP_W-1:0] smp_rht,
    output logic signed [SMP_W-1:0] lft_out,
    output logic signed [SMP_W-1:0] rht_out,
    output logic                    running,
    output logic                    overrun,
    output logic                    underrun
`ifdef CODEC_SEQ_STATS_EN
    ,
    output logic [15:0]             ovr_cnt,
    output logic [15:0]             udr_cnt
`endif
);

    codec_state_e state_q, state_d;
    smp_pair_t    smp_q, smp_d;
    smp_pair_t    play_q, play_d;
    logic         smp_vld_q, smp_vld_d;
    logic         fresh_q, fresh_d;
    logic         first_q, first_d;
    logic         ovr_q, ovr_d;
    logic         udr_q, udr_d;
    logic         hold_ld, settle_ld;
    logic         hold_tc, settle_tc;

    codec_seq_tmr #(.N(RST_CYC)) u_hold_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_ld),
        .load_val ('0),
        .en       (state_q == ST_HOLD),
        .tc       (hold_tc)
    );

    codec_seq_tmr #(.N(SETTLE_FRM)) u_settle_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_ld),
        .load_val ('0),
        .en       ((state_q == ST_SETTLE) && intf_valid),
        .tc       (settle_tc)
    );

    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        play_d    = play_q;
        smp_vld_d = smp_vld_q;
        fresh_d   = fresh_q;
        first_d   = first_q;
        ovr_d     = ovr_q;
        udr_d     = udr_q;
        hold_ld   = 1'b0;
        settle_ld = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (hold_tc) begin
                    state_d = ST_SETTLE;
                    hold_ld = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (intf_valid && settle_tc) begin
                    state_d   = ST_RUN;
                    settle_ld = 1'b1;
                end
            end
            ST_RUN: begin
                if (intf_valid) begin
                    if (smp_vld_q && !smp_rdy) begin
                        ovr_d = 1'b1;
                    end else begin
                        smp_d     = '{lft: lft_in, rht: rht_in};
                        smp_vld_d = 1'b1;
                    end
                    // A processed pair landing with the frame strobe still feeds that frame
                    if (!fresh_q && !proc_vld && !first_q) begin
                        udr_d = 1'b1;
                    end
                    fresh_d = 1'b0;
                    first_d = 1'b0;
                end else if (smp_vld_q && smp_rdy) begin
                    smp_vld_d = 1'b0;
                end
                if (proc_vld) begin
                    play_d = '{lft: proc_lft, rht: proc_rht};
                    if (!intf_valid) begin
                        fresh_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_HOLD;
        endcase

        if (restart) begin
            state_d   = ST_HOLD;
            hold_ld   = 1'b1;
            settle_ld = 1'b1;
            smp_vld_d = 1'b0;
            play_d    = '0;
            fresh_d   = 1'b0;
            first_d   = 1'b1;
            ovr_d     = 1'b0;
            udr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HOLD;
            smp_q     <= '0;
            play_q    <= '0;
            smp_vld_q <= 1'b0;
            fresh_q   <= 1'b0;
            first_q   <= 1'b1;
            ovr_q     <= 1'b0;
            udr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            play_q    <= play_d;
            smp_vld_q <= smp_vld_d;
            fresh_q   <= fresh_d;
            first_q   <= first_d;
            ovr_q     <= ovr_d;
            udr_q     <= udr_d;
        end
    end

    assign running     = (state_q == ST_RUN);
    assign codec_rst_n = (state_q != ST_HOLD);
    assign smp_vld     = smp_vld_q;
    assign smp_lft     = smp_q.lft;
    assign smp_rht     = smp_q.rht;
    assign lft_out     = running ? play_q.lft : '0;
    assign rht_out     = running ? play_q.rht : '0;
    assign overrun     = ovr_q;
    assign underrun    = udr_q;

`ifdef CODEC_SEQ_STATS_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic [15:0] udr_cnt_q, udr_cnt_d;
    logic        ovr_evt, udr_evt;

    assign ovr_evt = running && intf_valid && smp_vld_q && !smp_rdy;
    assign udr_evt = running && intf_valid && !fresh_q && !proc_vld && !first_q;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        udr_cnt_d = udr_cnt_q;
        if (restart) begin
            ovr_cnt_d = '0;
            udr_cnt_d = '0;
        end else begin
            if (ovr_evt && (ovr_cnt_q != 16'hFFFF)) begin
                ovr_cnt_d = ovr_cnt_q + 16'd1;
            end
            if (udr_evt && (udr_cnt_q != 16'hFFFF)) begin
                udr_cnt_d = udr_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= '0;
            udr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
            udr_cnt_q <= udr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
    assign udr_cnt = udr_cnt_q;
`endif

endmodule

// File: tb/tb_codec_seq.sv
// tb/tb_codec_seq.sv - scoreboard bench for codec_seq; CODEC_SEQ_STATS_EN enables the counter checks
module tb_codec_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        intf_valid;
    logic [15:0] lft_in, rht_in;
    logic        smp_rdy;
    logic        proc_vld;
    logic [15:0] proc_lft, proc_rht;
    logic        codec_rst_n;
    logic        smp_vld;
    logic [15:0] smp_lft, smp_rht;
    logic [15:0] lft_out, rht_out;
    logic        running, overrun, underrun;
`ifdef CODEC_SEQ_STATS_EN
    logic [15:0] ovr_cnt, udr_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    codec_seq #(.RST_CYC(1024), .SETTLE_FRM(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (restart),
        .intf_valid  (intf_valid),
        .lft_in      (lft_in),
        .rht_in      (rht_in),
        .smp_rdy     (smp_rdy),
        .proc_vld    (proc_vld),
        .proc_lft    (proc_lft),
        .proc_rht    (proc_rht),
        .codec_rst_n (codec_rst_n),
        .smp_vld     (smp_vld),
        .smp_lft     (smp_lft),
        .smp_rht     (smp_rht),
        .lft_out     (lft_out),
        .rht_out     (rht_out),
        .running     (running),
        .overrun     (overrun),
        .underrun    (underrun)
`ifdef CODEC_SEQ_STATS_EN
        ,
        .ovr_cnt     (ovr_cnt),
        .udr_cnt     (udr_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && smp_vld && smp_rdy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL smp_unexpected: got %h/%h, required no transfer", smp_lft, smp_rht);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({smp_lft, smp_rht} !== e) begin
                    n_bad++;
                    $display("FAIL smp_pair: got %h/%h, required %h/%h", smp_lft, smp_rht, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input logic pv,
                         input logic [15:0] pl, input logic [15:0] pr);
        intf_valid = 1'b1;
        lft_in     = l;
        rht_in     = r;
        proc_vld   = pv;
        proc_lft   = pl;
        proc_rht   = pr;
        idle(1);
        intf_valid = 1'b0;
        proc_vld   = 1'b0;
    endtask

    task automatic run_up();
        int n;
        n = 0;
        while (codec_rst_n !== 1'b1 && n < 2000) begin
            idle(1);
            n++;
        end
        chk("codec_rst_rise_cycles", n, 1024);
        for (int i = 0; i < 15; i++) begin
            frame(16'h5A00 + 16'(i), 16'hA500, 1'b0, 16'h0, 16'h0);
            idle(2);
        end
        chk("running_before_16th", running, 0);
        frame(16'h5AFF, 16'hA5FF, 1'b0, 16'h0, 16'h0);
        chk("running_after_16th", running, 1);
        idle(2);
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; intf_valid = 1'b0; smp_rdy = 1'b1; proc_vld = 1'b0;
        lft_in = '0; rht_in = '0; proc_lft = '0; proc_rht = '0;
        idle(3);
        chk("rst_codec_rst_n", codec_rst_n, 0);
        chk("rst_smp_vld", smp_vld, 0);
        chk("rst_smp_lft", smp_lft, 0);
        chk("rst_lft_out", lft_out, 0);
        chk("rst_running", running, 0);
        chk("rst_flags", {overrun, underrun}, 0);
        rst_n = 1'b1;
        run_up();

        exp_q.push_back({16'h1234, 16'hEDCB});
        frame(16'h1234, 16'hEDCB, 1'b0, 16'h0, 16'h0);
        chk("cap_smp_vld_set", smp_vld, 1);
        idle(1);
        chk("cap_smp_vld_clr", smp_vld, 0);
        chk("cap_overrun", overrun, 0);
        chk("first_frame_exempt", underrun, 0);

        proc_vld = 1'b1; proc_lft = 16'h7FFF; proc_rht = 16'h8000;
        idle(1);
        proc_vld = 1'b0;
        chk("play_lft", lft_out, 16'h7FFF);
        chk("play_rht", rht_out, 16'h8000);
        exp_q.push_back({16'h1111, 16'h2222});
        frame(16'h1111, 16'h2222, 1'b0, 16'h0, 16'h0);
        chk("udr_after_fresh_frame", underrun, 0);
        idle(1);
        exp_q.push_back({16'h3333, 16'h4444});
        frame(16'h3333, 16'h4444, 1'b0, 16'h0, 16'h0);
        chk("udr_second_frame", underrun, 1);
        chk("udr_hold_lft", lft_out, 16'h7FFF);
        chk("udr_hold_rht", rht_out, 16'h8000);
        idle(1);

        smp_rdy = 1'b0;
        exp_q.push_back({16'h0001, 16'h0011});
        frame(16'h0001, 16'h0011, 1'b0, 16'h0, 16'h0);
        frame(16'h0002, 16'h0022, 1'b0, 16'h0, 16'h0);
        chk("ovr_held_lft", smp_lft, 16'h0001);
        chk("ovr_flag", overrun, 1);
        chk("ovr_smp_vld", smp_vld, 1);
`ifdef CODEC_SEQ_STATS_EN
        chk("ovr_cnt_one", ovr_cnt, 1);
`endif
        smp_rdy = 1'b1;
        idle(1);
        chk("ovr_sticky", overrun, 1);

        restart = 1'b1;
        idle(1);
        restart = 1'b0;
        chk("rs_codec_rst_n", codec_rst_n, 0);
        chk("rs_running", running, 0);
        chk("rs_overrun", overrun, 0);
        chk("rs_underrun", underrun, 0);
        chk("rs_lft_out", lft_out, 0);
`ifdef CODEC_SEQ_STATS_EN
        chk("rs_ovr_cnt", ovr_cnt, 0);
`endif
        run_up();

        exp_q.push_back({16'h0A0A, 16'h0B0B});
        frame(16'h0A0A, 16'h0B0B, 1'b1, 16'h0102, 16'h0304);
        chk("coin1_underrun", underrun, 0);
        chk("coin1_lft_out", lft_out, 16'h0102);
        idle(1);
        exp_q.push_back({16'h0C0C, 16'h0D0D});
        frame(16'h0C0C, 16'h0D0D, 1'b1, 16'h0506, 16'h0708);
        chk("coin2_underrun", underrun, 0);
        chk("coin2_rht_out", rht_out, 16'h0708);
        idle(1);
        exp_q.push_back({16'h0E0E, 16'h0F0F});
        frame(16'h0E0E, 16'h0F0F, 1'b0, 16'h0, 16'h0);
        chk("coin3_underrun", underrun, 1);
        idle(2);

`ifdef CODEC_SEQ_STATS_EN
        smp_rdy = 1'b0;
        intf_valid = 1'b1;
        lft_in = 16'hBEEF; rht_in = 16'hCAFE;
        idle(70001);
        intf_valid = 1'b0;
        chk("ovr_cnt_sat", ovr_cnt, 16'hFFFF);
`endif

        smp_rdy = 1'b0;
        frame(16'h4242, 16'h2424, 1'b0, 16'h0, 16'h0);
        chk("abort_pre_vld", smp_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_smp_vld", smp_vld, 0);
        chk("abort_codec_rst_n", codec_rst_n, 0);
        chk("abort_lft_out", lft_out, 0);
        idle(2);
        rst_n = 1'b1;
        smp_rdy = 1'b1;
        idle(20);
        chk("abort_post_vld", smp_vld, 0);
        chk("abort_post_running", running, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
